// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   UART transmitter with an input FIFO. Words pushed with a valid/ready
//   handshake are queued, then sent one frame each:
//   start(0), DW data bits, optional parity, stop bits (1), optional idle gap (1).
//   Frames for queued words follow each other with no idle cycle in between.
//
// Parameters
//   CLK_DIV     clk cycles per UART bit (>= 2)
//   DW          data bits per frame (5..9)
//   PARITY      0 = none, 1 = even (^data), 2 = odd (~^data)
//   MSB_FIRST   1 = bit DW-1 first, 0 = bit 0 first
//   STOP_BITS   stop bits, 1 or 2
//   IDLE_GAP    extra idle bit periods after the stop bits, 0..3
//   FIFO_DEPTH  FIFO entries, power of 2, >= 2
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   tx_data   in   word to transmit
//   tx_vld    in   tx_data valid
//   tx_rdy    out  FIFO can accept (push on tx_vld & tx_rdy)
//   uart_tx   out  registered serial line, idle high
//   busy      out  frame in progress
//   fifo_cnt  out  current FIFO occupancy
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLK_DIV    = 868,
    parameter int DW         = 8,
    parameter int PARITY     = 1,
    parameter int MSB_FIRST  = 1,
    parameter int STOP_BITS  = 1,
    parameter int IDLE_GAP   = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DW-1:0]                 tx_data,
    input  logic                          tx_vld,
    output logic                          tx_rdy,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(CLK_DIV);
    localparam int BW = 4;

    localparam logic [TW-1:0] TMR_LAST  = TW'(CLK_DIV - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DW - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [BW-1:0] GAP_LAST  = BW'(IDLE_GAP - 1);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    // FIFO storage and bookkeeping
    logic [DW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;

    // Transmit FSM state
    logic [2:0]    r_state;
    logic [TW-1:0] r_tmr;
    logic [BW-1:0] r_bit_cnt;
    logic [DW-1:0] r_shift;
    logic          r_par;
    logic          r_tx;

    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_tc;
    logic          w_frame_end;
    logic [DW-1:0] w_head;
    logic          w_head_par;
    logic          w_out_bit;
    logic [DW-1:0] w_shift_next;

    assign tx_rdy   = (r_cnt != CNT_FULL);
    assign fifo_cnt = r_cnt;
    assign uart_tx  = r_tx;
    assign busy     = (r_state != S_IDLE);

    assign w_push  = tx_vld & tx_rdy;
    assign w_empty = (r_cnt == '0);
    assign w_tc    = (r_tmr == TMR_LAST);
    assign w_head  = r_mem[r_rd_ptr];

    assign w_head_par = (PARITY == 2) ? ~^w_head : ^w_head;

    // Last timer tick of the frame's final high period (stop or gap).
    assign w_frame_end = w_tc &&
        (((r_state == S_STOP) && (r_bit_cnt == STOP_LAST) && (IDLE_GAP == 0)) ||
         ((r_state == S_GAP)  && (r_bit_cnt == GAP_LAST)));

    // Pop from idle, or directly at frame end so queued frames abut.
    assign w_pop = !w_empty && ((r_state == S_IDLE) || w_frame_end);

    // Next data bit always sits at the head of the shift register.
    assign w_out_bit    = (MSB_FIRST != 0) ? r_shift[DW-1] : r_shift[0];
    assign w_shift_next = (MSB_FIRST != 0) ? {r_shift[DW-2:0], 1'b0}
                                           : {1'b0, r_shift[DW-1:1]};

    // NOTE: storage array has no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW + 1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW + 1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_tmr     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            if (r_state != S_IDLE) begin
                if (!w_tc) begin
                    r_tmr <= r_tmr + TW'(1);
                end else begin
                    r_tmr <= '0;
                    case (r_state)
                        S_START: begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                            r_tx      <= w_out_bit;
                            r_shift   <= w_shift_next;
                        end
                        S_DATA: begin
                            if (r_bit_cnt != DATA_LAST) begin
                                r_bit_cnt <= r_bit_cnt + BW'(1);
                                r_tx      <= w_out_bit;
                                r_shift   <= w_shift_next;
                            end else if (PARITY != 0) begin
                                r_state <= S_PAR;
                                r_tx    <= r_par;
                            end else begin
                                r_state   <= S_STOP;
                                r_bit_cnt <= '0;
                                r_tx      <= 1'b1;
                            end
                        end
                        S_PAR: begin
                            r_state   <= S_STOP;
                            r_bit_cnt <= '0;
                            r_tx      <= 1'b1;
                        end
                        S_STOP: begin
                            if (r_bit_cnt != STOP_LAST) begin
                                r_bit_cnt <= r_bit_cnt + BW'(1);
                            end else if (IDLE_GAP != 0) begin
                                r_state   <= S_GAP;
                                r_bit_cnt <= '0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                        S_GAP: begin
                            if (r_bit_cnt != GAP_LAST) begin
                                r_bit_cnt <= r_bit_cnt + BW'(1);
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                        end
                    endcase
                end
            end

            // NOTE: a later non-blocking assignment to the same register wins,
            // so a pop here overrides the frame-end return to IDLE above.
            if (w_pop) begin
                r_state <= S_START;
                r_tmr   <= '0;
                r_shift <= w_head;
                r_par   <= w_head_par;
                r_tx    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Three differently configured transmitters share one clock. Inputs and
//   outputs are logged per clock edge; a frame-level reference model replays the
//   logged inputs and predicts line, busy, occupancy and ready for every edge.
//   Index k in the logs means "the edge numbered k" (inputs) or "just after
//   edge k" (outputs, sampled on the falling edge).
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int N = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, rst_c;
    logic       a_vld, b_vld, c_vld;
    logic [7:0] a_data;
    logic [6:0] b_data;
    logic [7:0] c_data;
    logic       a_rdy, b_rdy, c_rdy;
    logic       a_tx, b_tx, c_tx;
    logic       a_busy, b_busy, c_busy;
    logic [3:0] a_cnt;
    logic [2:0] b_cnt;
    logic [1:0] c_cnt;

    // A: default frame, fast bit clock
    uart_tx_fifo #(.CLK_DIV(4)) dut_a (
        .clk(clk), .rst(rst_a), .tx_data(a_data), .tx_vld(a_vld),
        .tx_rdy(a_rdy), .uart_tx(a_tx), .busy(a_busy), .fifo_cnt(a_cnt)
    );

    // B: 7 bits, odd parity, LSB first, two stop bits, no gap, 4-deep FIFO
    uart_tx_fifo #(.CLK_DIV(4), .DW(7), .PARITY(2), .MSB_FIRST(0), .STOP_BITS(2),
                   .IDLE_GAP(0), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst_b), .tx_data(b_data), .tx_vld(b_vld),
        .tx_rdy(b_rdy), .uart_tx(b_tx), .busy(b_busy), .fifo_cnt(b_cnt)
    );

    // C: no parity, no gap, 2-deep FIFO
    uart_tx_fifo #(.CLK_DIV(3), .PARITY(0), .IDLE_GAP(0), .FIFO_DEPTH(2)) dut_c (
        .clk(clk), .rst(rst_c), .tx_data(c_data), .tx_vld(c_vld),
        .tx_rdy(c_rdy), .uart_tx(c_tx), .busy(c_busy), .fifo_cnt(c_cnt)
    );

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    logic       vlog [3][N];
    logic [8:0] dlog [3][N];
    logic       lhist [3][N];
    logic       bhist [3][N];
    logic       rhist [3][N];
    logic [3:0] chist [3][N];
    logic       exp_line [3][N];
    logic       exp_busy [3][N];
    logic       exp_rdy [3][N];
    logic [3:0] exp_cnt [3][N];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc + 1 < N) begin
            vlog[0][cyc+1] <= a_vld;
            vlog[1][cyc+1] <= b_vld;
            vlog[2][cyc+1] <= c_vld;
            dlog[0][cyc+1] <= {1'b0, a_data};
            dlog[1][cyc+1] <= {2'b0, b_data};
            dlog[2][cyc+1] <= {1'b0, c_data};
        end
    end

    always @(negedge clk) begin
        if (cyc < N) begin
            lhist[0][cyc] <= a_tx;
            lhist[1][cyc] <= b_tx;
            lhist[2][cyc] <= c_tx;
            bhist[0][cyc] <= a_busy;
            bhist[1][cyc] <= b_busy;
            bhist[2][cyc] <= c_busy;
            rhist[0][cyc] <= a_rdy;
            rhist[1][cyc] <= b_rdy;
            rhist[2][cyc] <= c_rdy;
            chist[0][cyc] <= a_cnt;
            chist[1][cyc] <= {1'b0, b_cnt};
            chist[2][cyc] <= {2'b0, c_cnt};
        end
    end

    // Frame-level reference: a word queue plus "line free from edge X".
    // Frame bits are built from the word with plain arithmetic.
    task automatic run_model(input int d, input int k0, input int k1, input int clk_div,
                             input int dw, input int par, input int msb, input int stop,
                             input int gap, input int depth);
        logic [8:0] q[$];
        bit         cur[$];
        logic [8:0] w;
        logic [8:0] mask;
        int         fs;
        int         free_at;
        int         len;
        int         cnt_before;
        bit         in_frame;
        mask    = 9'((1 << dw) - 1);
        fs      = -1;
        free_at = k0;
        len     = clk_div * (1 + dw + ((par != 0) ? 1 : 0) + stop + gap);
        for (int k = k0; k <= k1; k++) begin
            cnt_before = q.size();
            if (q.size() > 0 && k >= free_at) begin
                w = q.pop_front();
                cur.delete();
                cur.push_back(1'b0);
                for (int i = 0; i < dw; i++) cur.push_back(w[(msb != 0) ? dw - 1 - i : i]);
                if (par != 0) cur.push_back(bit'((($countones(w) % 2) == 1) != (par == 2)));
                repeat (stop + gap) cur.push_back(1'b1);
                fs      = k;
                free_at = k + len;
            end
            if (vlog[d][k] === 1'b1 && cnt_before != depth) q.push_back(dlog[d][k] & mask);
            in_frame       = (fs >= 0) && (k < fs + len);
            exp_busy[d][k] = in_frame;
            exp_line[d][k] = in_frame ? cur[(k - fs) / clk_div] : 1'b1;
            exp_cnt[d][k]  = 4'(q.size());
            exp_rdy[d][k]  = (q.size() != depth);
        end
    endtask

    function automatic int first_diff(input int d, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            if (lhist[d][k] !== exp_line[d][k] || bhist[d][k] !== exp_busy[d][k] ||
                chist[d][k] !== exp_cnt[d][k]  || rhist[d][k] !== exp_rdy[d][k]) return k;
        end
        return -1;
    endfunction

    task automatic show_diff(input string name, input int d, input int k);
        $display("FAIL %s @edge %0d: tx/busy/cnt/rdy got %b/%b/%0d/%b want %b/%b/%0d/%b",
                 name, k, lhist[d][k], bhist[d][k], chist[d][k], rhist[d][k],
                 exp_line[d][k], exp_busy[d][k], exp_cnt[d][k], exp_rdy[d][k]);
    endtask

    function automatic int count_busy(input int d, input int k0, input int k1);
        int n = 0;
        for (int k = k0; k <= k1; k++) if (bhist[d][k] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_frames(input int d, input int k0, input int k1);
        int n = 0;
        for (int k = k0 + 1; k <= k1; k++)
            if (lhist[d][k] === 1'b0 && (lhist[d][k-1] === 1'b1 && bhist[d][k-1] === 1'b0 ||
                                         bhist[d][k-1] === 1'b1 && exp_busy[d][k-1] === 1'b1 &&
                                         lhist[d][k-1] === 1'b1 && bhist[d][k] === 1'b1 &&
                                         chist[d][k] !== chist[d][k-1] + 4'd1 &&
                                         chist[d][k] !== chist[d][k-1]))
                n++;
        return n;
    endfunction

    function automatic int max_cnt(input int d, input int k0, input int k1);
        int m = 0;
        for (int k = k0; k <= k1; k++) if (int'(chist[d][k]) > m) m = int'(chist[d][k]);
        return m;
    endfunction

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        a_vld = 1'b0; b_vld = 1'b0; c_vld = 1'b0;
        a_data = '0; b_data = '0; c_data = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({a_tx, a_busy, a_rdy} !== 3'b101) $display("FAIL reset_a_flags: tx/busy/rdy got %b want 101", {a_tx, a_busy, a_rdy});
        else n_pass++;
        n_checks++;
        if (a_cnt !== 4'd0) $display("FAIL reset_a_cnt: got %0d want 0", a_cnt);
        else n_pass++;
        n_checks++;
        if ({b_tx, b_busy, b_rdy} !== 3'b101) $display("FAIL reset_b_flags: tx/busy/rdy got %b want 101", {b_tx, b_busy, b_rdy});
        else n_pass++;
        n_checks++;
        if (b_cnt !== 3'd0) $display("FAIL reset_b_cnt: got %0d want 0", b_cnt);
        else n_pass++;
        n_checks++;
        if ({c_tx, c_busy, c_rdy} !== 3'b101) $display("FAIL reset_c_flags: tx/busy/rdy got %b want 101", {c_tx, c_busy, c_rdy});
        else n_pass++;
        n_checks++;
        if (c_cnt !== 2'd0) $display("FAIL reset_c_cnt: got %0d want 0", c_cnt);
        else n_pass++;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        int k0, k1, idx, nb;
        k0 = cyc + 1;
        a_data = 8'h01; a_vld = 1'b1;
        @(negedge clk);
        a_vld = 1'b0;
        repeat (60) @(negedge clk);
        k1 = cyc - 1;
        run_model(0, k0, k1, 4, 8, 1, 1, 1, 1, 8);
        idx = first_diff(0, k0, k1);
        n_checks++;
        if (idx !== -1) show_diff("single_frame", 0, idx);
        else n_pass++;
        n_checks++;
        if ({lhist[0][k0], lhist[0][k0+1]} !== 2'b10)
            $display("FAIL single_start_edge: tx at push/push+1 got %b want 10", {lhist[0][k0], lhist[0][k0+1]});
        else n_pass++;
        nb = count_busy(0, k0, k1);
        n_checks++;
        if (nb !== 48) $display("FAIL single_busy_len: got %0d want 48", nb);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int k0, k1, idx, nb, m;
        logic [7:0] words [3];
        words[0] = 8'h23; words[1] = 8'h45; words[2] = 8'h89;
        k0 = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            a_data = words[i]; a_vld = 1'b1;
            @(negedge clk);
        end
        a_vld = 1'b0;
        repeat (160) @(negedge clk);
        k1 = cyc - 1;
        run_model(0, k0, k1, 4, 8, 1, 1, 1, 1, 8);
        idx = first_diff(0, k0, k1);
        n_checks++;
        if (idx !== -1) show_diff("back_to_back", 0, idx);
        else n_pass++;
        m = max_cnt(0, k0, k1);
        n_checks++;
        if (m !== 2) $display("FAIL b2b_peak_cnt: got %0d want 2", m);
        else n_pass++;
        nb = count_busy(0, k0, k1);
        n_checks++;
        if (nb !== 144) $display("FAIL b2b_busy_len: got %0d want 144", nb);
        else n_pass++;
    endtask

    task automatic test_config_b();
        int k0, k1, idx, nb;
        k0 = cyc + 1;
        b_data = 7'h55; b_vld = 1'b1;
        @(negedge clk);
        b_vld = 1'b0;
        repeat (60) @(negedge clk);
        k1 = cyc - 1;
        run_model(1, k0, k1, 4, 7, 2, 0, 2, 0, 4);
        idx = first_diff(1, k0, k1);
        n_checks++;
        if (idx !== -1) show_diff("cfg_b_frame", 1, idx);
        else n_pass++;
        nb = count_busy(1, k0, k1);
        n_checks++;
        if (nb !== 44) $display("FAIL cfg_b_frame_len: got %0d want 44", nb);
        else n_pass++;
    endtask

    task automatic test_fifo_full();
        int k0, k1, idx, m, k4;
        logic [6:0] words [6];
        words[0] = 7'h11; words[1] = 7'h22; words[2] = 7'h33;
        words[3] = 7'h44; words[4] = 7'h55; words[5] = 7'h66;
        k0 = cyc + 1;
        b_data = 7'h0F; b_vld = 1'b1;
        @(negedge clk);
        b_vld = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            b_data = words[i]; b_vld = 1'b1;
            @(negedge clk);
        end
        b_vld = 1'b0;
        repeat (250) @(negedge clk);
        k1 = cyc - 1;
        run_model(1, k0, k1, 4, 7, 2, 0, 2, 0, 4);
        idx = first_diff(1, k0, k1);
        n_checks++;
        if (idx !== -1) show_diff("fifo_full", 1, idx);
        else n_pass++;
        m = max_cnt(1, k0, k1);
        n_checks++;
        if (m !== 4) $display("FAIL full_peak_cnt: got %0d want 4", m);
        else n_pass++;
        k4 = -1;
        for (int k = k0; k <= k1; k++) if (k4 < 0 && chist[1][k] === 4'd4) k4 = k;
        n_checks++;
        if (k4 < 0 || rhist[1][k4] !== 1'b0) $display("FAIL full_rdy_low: got %b want 0 (edge %0d)", (k4 < 0) ? 1'bx : rhist[1][k4], k4);
        else n_pass++;
        // One frame for 0x0F plus the four words that fit: 5 * 44 busy cycles.
        m = count_busy(1, k0, k1);
        n_checks++;
        if (m !== 220) $display("FAIL full_frames_busy: got %0d want 220", m);
        else n_pass++;
    endtask

    task automatic test_random(input int d, input int cycles, input int drain, input string name);
        int k0, k1, idx;
        k0 = cyc + 1;
        for (int i = 0; i < cycles; i++) begin
            if (d == 1) begin
                b_vld = ($urandom_range(0, 3) == 0);
                b_data = 7'($urandom);
            end else begin
                c_vld = ($urandom_range(0, 4) < 2);
                c_data = 8'($urandom);
            end
            @(negedge clk);
        end
        b_vld = 1'b0; c_vld = 1'b0;
        repeat (drain) @(negedge clk);
        k1 = cyc - 1;
        if (d == 1) run_model(1, k0, k1, 4, 7, 2, 0, 2, 0, 4);
        else        run_model(2, k0, k1, 3, 8, 0, 1, 1, 0, 2);
        idx = first_diff(d, k0, k1);
        n_checks++;
        if (idx !== -1) show_diff(name, d, idx);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int k0, k1, k_rel, idx, nb;
        logic [7:0] words [4];
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h7E; words[3] = 8'h81;
        k0 = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            a_data = words[i]; a_vld = 1'b1;
            @(negedge clk);
        end
        a_vld = 1'b0;
        repeat (11) @(negedge clk);
        k1 = cyc - 1;
        run_model(0, k0, k1, 4, 8, 1, 1, 1, 1, 8);
        idx = first_diff(0, k0, k1);
        n_checks++;
        if (idx !== -1) show_diff("pre_reset", 0, idx);
        else n_pass++;
        #1;
        rst_a = 1'b1;
        #1;
        n_checks++;
        if ({a_tx, a_busy, a_rdy} !== 3'b101) $display("FAIL async_reset_flags: tx/busy/rdy got %b want 101", {a_tx, a_busy, a_rdy});
        else n_pass++;
        n_checks++;
        if (a_cnt !== 4'd0) $display("FAIL async_reset_cnt: got %0d want 0", a_cnt);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        k_rel = cyc + 1;
        repeat (100) @(negedge clk);
        a_data = 8'h5A; a_vld = 1'b1;
        @(negedge clk);
        a_vld = 1'b0;
        repeat (60) @(negedge clk);
        k1 = cyc - 1;
        run_model(0, k_rel, k1, 4, 8, 1, 1, 1, 1, 8);
        idx = first_diff(0, k_rel, k1);
        n_checks++;
        if (idx !== -1) show_diff("post_reset", 0, idx);
        else n_pass++;
        nb = count_busy(0, k_rel, k1);
        n_checks++;
        if (nb !== 48) $display("FAIL post_reset_busy: got %0d want 48", nb);
        else n_pass++;
    endtask

    task automatic test_full_pop();
        int k0, k1, idx, nb;
        logic [7:0] words [4];
        words[0] = 8'hC3; words[1] = 8'h18; words[2] = 8'hE7; words[3] = 8'h42;
        k0 = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            c_data = words[i]; c_vld = 1'b1;
            @(negedge clk);
        end
        while (cyc < k0 + 32) @(negedge clk);
        c_vld = 1'b0;
        repeat (110) @(negedge clk);
        k1 = cyc - 1;
        run_model(2, k0, k1, 3, 8, 0, 1, 1, 0, 2);
        idx = first_diff(2, k0, k1);
        n_checks++;
        if (idx !== -1) show_diff("full_pop", 2, idx);
        else n_pass++;
        // Edge k0+1: pop C3 and push 18 together -> count stays 1.
        n_checks++;
        if ({chist[2][k0], chist[2][k0+1]} !== {4'd1, 4'd1})
            $display("FAIL push_pop_same_edge: cnt got %0d,%0d want 1,1", chist[2][k0], chist[2][k0+1]);
        else n_pass++;
        // Edge k0+31: full, frame ends and pops; the held word is refused.
        n_checks++;
        if ({rhist[2][k0+30], chist[2][k0+31], chist[2][k0+32]} !== {1'b0, 4'd1, 4'd2})
            $display("FAIL pop_at_full: rdy/cnt/cnt got %b/%0d/%0d want 0/1/2", rhist[2][k0+30], chist[2][k0+31], chist[2][k0+32]);
        else n_pass++;
        nb = count_busy(2, k0, k1);
        n_checks++;
        if (nb !== 120) $display("FAIL full_pop_busy: got %0d want 120", nb);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_config_b();
        test_fifo_full();
        test_random(1, 500, 240, "random_b");
        test_reset_mid();
        test_full_pop();
        test_random(2, 500, 110, "random_c");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
